multiplier_post_adder_proposed: RTL and testbench

- Stage directly downstream of the multiplier output manager.
- Consumes the 90-bit partial-product bus M and the SIMD carry-correction bus M_SIMD.
- Sums the two 45-bit partial products with a selectable Z operand (0, C, or P feedback) in a lane-partitioned 48-bit adder, then registers the result.
- Produces the P output and per-lane carry-outs.
- Static options come from the serial configuration chain shared by the DSP stages.

---
 rtl/multiplier_post_adder_proposed.sv | 169 ++++++++++++++++
 tb/tb_multiplier_post_adder_proposed.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/multiplier_post_adder_proposed.sv
//------------------------------------------------------------------------------
// multiplier_post_adder_proposed
//
// Post-adder stage that sits directly after the multiplier output manager.
// The two 45-bit partial products X = M[44:0] and Y = M[89:45] are
// sign-extended to 48 bits. They are summed with a selectable Z operand
// (0, C or the P register) in a lane-partitioned adder (one 48-bit lane,
// two 24-bit lanes or four 12-bit lanes). The result can optionally be
// registered.
//
// Ports:
//   clk                  rising-edge clock for all state
//   RSTP                 synchronous reset of P/carry registers; its polarity
//                        is set by the IS_RSTP_INVERTED configuration bit
//   M[89:0]              {Y, X} partial products, two's complement
//   M_SIMD               per-lane carry-in; only bits [3:0] are used
//   C[47:0]              external Z operand
//   OPMODE[1:0]          Z select: 00 = 0, 01 = P register, 1x = C
//   CEP                  clock enable of the P/carry registers
//   PREG                 1 = registered outputs, 0 = combinational outputs
//   P[47:0]              result
//   CARRYOUT[3:0]        per-lane carry-outs, packed by SIMD mode
//   configuration_*      3-bit serial configuration chain
//                        (IS_RSTP_INVERTED -> USE_SIMD[0] -> USE_SIMD[1])
//------------------------------------------------------------------------------
module multiplier_post_adder_proposed #(
   parameter int precision_loss_width = 16
) (
   input  logic                            clk,
   input  logic                            RSTP,
   input  logic [89:0]                     M,
   input  logic [precision_loss_width-1:0] M_SIMD,
   input  logic [47:0]                     C,
   input  logic [1:0]                      OPMODE,
   input  logic                            CEP,
   input  logic                            PREG,
   output logic [47:0]                     P,
   output logic [3:0]                      CARRYOUT,
   input  logic                            configuration_input,
   input  logic                            configuration_enable,
   output logic                            configuration_output
);

   typedef enum logic [1:0] {
      SIMD_ONE48     = 2'b00,
      SIMD_TWO24     = 2'b01,
      SIMD_FOUR12    = 2'b10,
      SIMD_ONE48_ALT = 2'b11
   } simd_mode_e;

   // Configuration chain state
   logic       r_is_rstp_inverted;
   logic [1:0] r_use_simd;

   // Result registers
   logic [47:0] r_p;
   logic [3:0]  r_co;

   // Datapath
   simd_mode_e  w_mode;
   logic        w_rst;
   logic [47:0] w_xe;
   logic [47:0] w_ye;
   logic [47:0] w_z;
   logic [49:0] w_sum48;
   logic [25:0] w_sum24 [2];
   logic [13:0] w_sum12 [4];
   logic [47:0] w_res;
   logic [3:0]  w_co;
   logic        w_unused_simd;

   // Only the four lane carry-ins are meaningful; the rest are ignored.
   assign w_unused_simd = ^M_SIMD;

   //---------------------------------------------------------------------------
   // Configuration shift chain
   //---------------------------------------------------------------------------
   // NOTE: static configuration bits are not reset; they hold whatever was
   // shifted in, and RSTP must not disturb them.
   always_ff @(posedge clk) begin
      if (configuration_enable) begin
         r_is_rstp_inverted <= configuration_input;
         r_use_simd[0]      <= r_is_rstp_inverted;
         r_use_simd[1]      <= r_use_simd[0];
      end
   end

   assign configuration_output = r_use_simd[1];
   assign w_mode               = simd_mode_e'(r_use_simd);
   assign w_rst                = RSTP ^ r_is_rstp_inverted;

   //---------------------------------------------------------------------------
   // Operand preparation
   //---------------------------------------------------------------------------
   assign w_xe = {{3{M[44]}}, M[44:0]};
   assign w_ye = {{3{M[89]}}, M[89:45]};

   // Feedback always comes from P register, even when PREG=0, so the
   // combinational P path never loops back into the adder.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path can
      // leave it unassigned and infer a latch.
      w_z = '0;
      unique case (OPMODE)
         2'b00:   w_z = '0;
         2'b01:   w_z = r_p;
         default: w_z = C;
      endcase
   end

   //---------------------------------------------------------------------------
   // Lane-partitioned adder: every lane width is computed in parallel, each
   // with two spare MSBs so the 3-operand carry (up to 2) is not lost. The
   // SIMD mode then selects which set of lanes forms the result.
   //---------------------------------------------------------------------------
   always_comb begin
      w_sum48 = {2'b00, w_xe} + {2'b00, w_ye} + {2'b00, w_z} + 50'(M_SIMD[0]);

      for (int k = 0; k < 2; k++) begin
         w_sum24[k] = {2'b00, w_xe[k*24 +: 24]} + {2'b00, w_ye[k*24 +: 24]}
                    + {2'b00, w_z[k*24 +: 24]}  + 26'(M_SIMD[k]);
      end

      for (int k = 0; k < 4; k++) begin
         w_sum12[k] = {2'b00, w_xe[k*12 +: 12]} + {2'b00, w_ye[k*12 +: 12]}
                    + {2'b00, w_z[k*12 +: 12]}  + 14'(M_SIMD[k]);
      end

      w_res = w_sum48[47:0];
      w_co  = {w_sum48[48], 3'b000};

      unique case (w_mode)
         SIMD_TWO24: begin
            w_res = {w_sum24[1][23:0], w_sum24[0][23:0]};
            w_co  = {w_sum24[1][24], 1'b0, w_sum24[0][24], 1'b0};
         end
         SIMD_FOUR12: begin
            w_res = {w_sum12[3][11:0], w_sum12[2][11:0],
                     w_sum12[1][11:0], w_sum12[0][11:0]};
            w_co  = {w_sum12[3][12], w_sum12[2][12],
                     w_sum12[1][12], w_sum12[0][12]};
         end
         default: begin
            // ONE48 and the unused encoding 11 both use the single 48-bit lane.
            w_res = w_sum48[47:0];
            w_co  = {w_sum48[48], 3'b000};
         end
      endcase
   end

   //---------------------------------------------------------------------------
   // Result registers: reset beats clock enable.
   //---------------------------------------------------------------------------
   // NOTE: sequential state is written with non-blocking assignments only, so
   // every register samples pre-edge values regardless of block ordering.
   always_ff @(posedge clk) begin
      if (w_rst) begin
         r_p  <= '0;
         r_co <= '0;
      end else if (CEP) begin
         r_p  <= w_res;
         r_co <= w_co;
      end
   end

   assign P        = PREG ? r_p  : w_res;
   assign CARRYOUT = PREG ? r_co : w_co;

endmodule

// File: tb/tb_multiplier_post_adder_proposed.sv
//------------------------------------------------------------------------------
// Testbench for multiplier_post_adder_proposed.
// The stimulus process drives one cycle at a time. It also runs an
// arithmetic reference model and queues the output expected during that
// cycle. A monitor samples the DUT on the falling edge and pops and compares
// the expected outputs.
//------------------------------------------------------------------------------
module tb_multiplier_post_adder_proposed;

   logic        clk = 1'b0;
   logic        RSTP;
   logic [89:0] M;
   logic [15:0] M_SIMD;
   logic [47:0] C;
   logic [1:0]  OPMODE;
   logic        CEP;
   logic        PREG;
   logic [47:0] P;
   logic [3:0]  CARRYOUT;
   logic        configuration_input;
   logic        configuration_enable;
   logic        configuration_output;

   always #5 clk = ~clk;

   multiplier_post_adder_proposed #(.precision_loss_width(16)) dut (
      .clk                  (clk),
      .RSTP                 (RSTP),
      .M                    (M),
      .M_SIMD               (M_SIMD),
      .C                    (C),
      .OPMODE               (OPMODE),
      .CEP                  (CEP),
      .PREG                 (PREG),
      .P                    (P),
      .CARRYOUT             (CARRYOUT),
      .configuration_input  (configuration_input),
      .configuration_enable (configuration_enable),
      .configuration_output (configuration_output)
   );

   typedef struct {
      logic [89:0] m;
      logic [15:0] ms;
      logic [47:0] c;
      logic [1:0]  op;
      logic        cep;
      logic        rstp;
      logic        preg;
      logic        cen;
      logic        cin;
   } stim_t;

   typedef struct {
      int          cyc;
      logic [47:0] p;
      logic [3:0]  co;
      logic        cfg;
      string       name;
   } exp_t;

   exp_t sb_q[$];
   int   cyc     = 0;
   int   n_tests = 0;
   int   n_fail  = 0;

   // Reference model state
   logic [47:0] mdl_p;
   logic [3:0]  mdl_co;
   logic        mdl_inv;
   logic [1:0]  mdl_use;
   int          cfg_cnt = 0;
   bit          p_known = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      n_tests++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   // Lane sums computed with plain 64-bit arithmetic: lanes = 1, 2 or 4,
   // lane carry = bit [width] of the lane sum, and the carry of lane k sits
   // at the top CARRYOUT bit of that lane's quarter group.
   function automatic logic [51:0] ref_add(input logic [89:0] m, input logic [15:0] ms,
                                           input logic [47:0] z, input logic [1:0] mode);
      longint unsigned xe, ye, zu, mask, s, p;
      logic [3:0] co;
      int n, w, lo;
      xe = longint'($signed(m[44:0]))  & 64'h0000_FFFF_FFFF_FFFF;
      ye = longint'($signed(m[89:45])) & 64'h0000_FFFF_FFFF_FFFF;
      zu = 64'(z);
      n  = (mode == 2'b01) ? 2 : (mode == 2'b10) ? 4 : 1;
      w  = 48 / n;
      mask = (64'd1 << w) - 64'd1;
      p  = 0;
      co = '0;
      for (int k = 0; k < n; k++) begin
         lo = k * w;
         s  = ((xe >> lo) & mask) + ((ye >> lo) & mask) + ((zu >> lo) & mask) + 64'(ms[k]);
         p  = p | ((s & mask) << lo);
         co[(k + 1) * (4 / n) - 1] = s[w];
      end
      return {co, p[47:0]};
   endfunction

   function automatic logic [89:0] mk_m(input longint x, input longint y);
      logic [63:0] xv, yv;
      xv = x;
      yv = y;
      return {yv[44:0], xv[44:0]};
   endfunction

   function automatic stim_t idle();
      stim_t s;
      s.m = '0; s.ms = '0; s.c = '0; s.op = 2'b00;
      s.cep = 1'b0; s.rstp = mdl_inv; s.preg = 1'b1; s.cen = 1'b0; s.cin = 1'b0;
      return s;
   endfunction

   // One clock cycle: apply inputs after the edge, queue the output expected
   // during this cycle, then advance the model across the next edge.
   task automatic go(input stim_t s, input string name);
      logic [51:0] r;
      logic [47:0] z;
      exp_t e;
      @(posedge clk);
      #1;
      M = s.m; M_SIMD = s.ms; C = s.c; OPMODE = s.op; CEP = s.cep;
      RSTP = s.rstp; PREG = s.preg;
      configuration_enable = s.cen; configuration_input = s.cin;

      z = (s.op == 2'b00) ? 48'd0 : (s.op == 2'b01) ? mdl_p : s.c;
      r = ref_add(s.m, s.ms, z, mdl_use);
      if (cfg_cnt >= 3 && p_known) begin
         e.cyc  = cyc;
         e.p    = s.preg ? mdl_p  : r[47:0];
         e.co   = s.preg ? mdl_co : r[51:48];
         e.cfg  = mdl_use[1];
         e.name = name;
         sb_q.push_back(e);
      end

      if (cfg_cnt >= 3 && (s.rstp ^ mdl_inv) === 1'b1) begin
         mdl_p = '0; mdl_co = '0; p_known = 1'b1;
      end else if (cfg_cnt >= 3 && s.cep) begin
         mdl_p = r[47:0]; mdl_co = r[51:48];
         if (s.op != 2'b01) p_known = 1'b1;
      end
      if (s.cen) begin
         mdl_use = {mdl_use[0], mdl_inv};
         mdl_inv = s.cin;
         cfg_cnt++;
      end
   endtask

   // Shift three bits, first bit ends in USE_SIMD[1], last in IS_RSTP_INVERTED.
   task automatic shift3(input logic b0, input logic b1, input logic b2);
      stim_t s;
      logic [2:0] bits;
      bits = {b0, b1, b2};
      for (int i = 2; i >= 0; i--) begin
         s = idle();
         s.cen = 1'b1;
         s.cin = bits[i];
         go(s, "cfg_shift");
      end
   endtask

   // Monitor: compare whatever expectations are due at this falling edge.
   always @(negedge clk) begin
      exp_t e;
      while (sb_q.size() > 0 && sb_q[0].cyc <= cyc) begin
         e = sb_q.pop_front();
         check({e.name, "/P"},        64'(P),                    64'(e.p));
         check({e.name, "/CARRYOUT"}, 64'(CARRYOUT),             64'(e.co));
         check({e.name, "/cfg_out"},  64'(configuration_output), 64'(e.cfg));
      end
   end

   initial begin
      stim_t s;
      RSTP = 1'b0; M = '0; M_SIMD = '0; C = '0; OPMODE = 2'b00; CEP = 1'b0;
      PREG = 1'b1; configuration_input = 1'b0; configuration_enable = 1'b0;

      // FOUR12 with inverted reset: RSTP=0 resets, RSTP=1 runs.
      shift3(1'b1, 1'b0, 1'b1);
      s = idle(); s.rstp = 1'b0; s.cep = 1'b1;
      go(s, "inv_rst_assert");
      s = idle(); s.rstp = 1'b0;
      go(s, "reset_state");
      for (int i = 0; i < 20; i++) begin
         s = idle();
         s.rstp = 1'b1;
         s.m    = {$urandom(), $urandom(), $urandom()};
         s.ms   = 16'($urandom());
         s.c    = {16'($urandom()), $urandom()};
         s.op   = 2'($urandom());
         s.cep  = 1'b1;
         go(s, "four12_inv_run");
      end

      // ONE48, normal reset polarity.
      shift3(1'b0, 1'b0, 1'b0);
      s = idle(); s.m = mk_m(3, 5); s.cep = 1'b1;
      go(s, "one48_3p5");
      s = idle();
      go(s, "one48_3p5_lat");

      // Accumulate from reset, hold, then reset with CEP=1.
      s = idle(); s.rstp = 1'b1; s.cep = 1'b1;
      go(s, "acc_reset");
      for (int i = 0; i < 4; i++) begin
         s = idle(); s.m = mk_m(1, 0); s.op = 2'b01; s.cep = 1'b1;
         go(s, "acc_step");
      end
      for (int i = 0; i < 2; i++) begin
         s = idle(); s.m = mk_m(1, 0); s.op = 2'b01;
         go(s, "acc_hold");
      end
      s = idle(); s.rstp = 1'b1; s.cep = 1'b1; s.m = mk_m(1, 0); s.op = 2'b01;
      go(s, "acc_rst_over_cep");
      s = idle();
      go(s, "acc_after_rst");

      // TWO24: lane 0 carry must not leak into lane 1.
      shift3(1'b0, 1'b1, 1'b0);
      s = idle(); s.op = 2'b10; s.c = 48'h000001_FFFFFF; s.m = mk_m(1, 0);
      s.cep = 1'b1; s.preg = 1'b0;
      go(s, "two24_comb");
      s = idle();
      go(s, "two24_reg");

      // FOUR12: X = -1 with all carry-ins set.
      shift3(1'b1, 1'b0, 1'b0);
      s = idle(); s.m = mk_m(-1, 0); s.ms = 16'h000F; s.cep = 1'b1; s.preg = 1'b0;
      go(s, "four12_ext");
      s = idle();
      go(s, "four12_ext_reg");

      // PREG=0 is same-cycle, yet P_reg still loads.
      shift3(1'b0, 1'b0, 1'b0);
      s = idle(); s.m = mk_m(7, 9); s.cep = 1'b1; s.preg = 1'b0;
      go(s, "preg0_comb");
      s = idle();
      go(s, "preg0_then_reg");

      // Randomized mix across all modes, polarities and controls.
      for (int i = 0; i < 300; i++) begin
         if (i % 40 == 0)
            shift3(1'($urandom()), 1'($urandom()), 1'($urandom()));
         s = idle();
         s.rstp = mdl_inv ^ (($urandom() % 16) == 0);
         if ($urandom() % 3 == 0)
            s.m = mk_m(longint'($urandom_range(0, 40)) - 20, longint'($urandom_range(0, 40)) - 20);
         else
            s.m = {$urandom(), $urandom(), $urandom()};
         s.ms   = 16'($urandom());
         s.c    = {16'($urandom()), $urandom()};
         s.op   = 2'($urandom());
         s.cep  = ($urandom() % 4) != 0;
         s.preg = 1'($urandom());
         go(s, "random");
      end

      for (int i = 0; i < 3; i++) go(idle(), "drain");
      for (int i = 0; i < 10 && sb_q.size() > 0; i++) @(negedge clk);
      @(negedge clk);
      check("scoreboard_empty", 64'(sb_q.size()), 64'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
